mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_rd_assembler.sv | 52 +++++
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial load/store controller.
// Holds the FSM state encoding, the req_size encodings and a helper
// that maps a size code to its transfer length in bytes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // req_size encodings; code 3 is treated as a word as well
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Number of byte transfers a request of the given size needs
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rd_assembler.sv
// Load-data assembler: collects read bytes into little-endian lanes, then zero/sign extends.
// Latency: a byte is visible on rdata the cycle after its capture edge; extension is combinational.
// Backpressure: none; capture is driven purely by the controller FSM.
module mem_rd_assembler
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        cap_en,
  input  logic [1:0]  lane,
  input  logic [7:0]  cap_byte,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] rdata
);

  logic [31:0] cap_q;
  logic [31:0] cap_d;

  // Next lane contents: cleared on a new request, one lane written per read byte
  always_comb begin
    cap_d = cap_q;
    if (clr) begin
      cap_d = 32'd0;
    end else if (cap_en) begin
      cap_d[{lane, 3'b000} +: 8] = cap_byte;
    end
  end

  // Lane register; cleared by reset so resp_rdata reads zero immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q <= 32'd0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // Width extension of the captured bytes; unread upper bytes never leak through
  always_comb begin
    rdata = cap_q;
    case (size)
      SZ_BYTE: rdata = sext ? {{24{cap_q[7]}}, cap_q[7:0]}
                            : {24'd0, cap_q[7:0]};
      SZ_HALF: rdata = sext ? {{16{cap_q[15]}}, cap_q[15:0]}
                            : {16'd0, cap_q[15:0]};
      default: rdata = cap_q;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store controller: splits byte/half/word requests into byte memory accesses.
// Latency: N+1 cycles from accept edge to resp_valid (N = 1/2/4 bytes); one request per N+2 cycles.
// Backpressure: req_ready only in IDLE; optional sign extension via MEM_ACCESS_SIGN_EXT_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_ACCESS_SIGN_EXT_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  // Low address bits that wrap; the upper bits of the base pass through untouched
  localparam logic [31:0] LO_MASK = (32'd1 << MEM_AW) - 32'd1;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        signed_q, signed_d;

  logic        req_signed_i;
  logic        accept;
  logic        cap_en;
  logic        last_byte;
  logic [31:0] xfer_addr;

`ifdef MEM_ACCESS_SIGN_EXT_EN
  assign req_signed_i = req_signed;
`else
  // Without the feature every load zero-extends
  assign req_signed_i = 1'b0;
`endif

  // Address of the current byte and end-of-transfer detection
  always_comb begin
    xfer_addr = (addr_q & ~LO_MASK) | ((addr_q + {30'd0, idx_q}) & LO_MASK);
    last_byte = ({1'b0, idx_q} == (size_bytes(size_q) - 3'd1));
  end

  // FSM next state, request latching and memory-side outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    signed_d   = signed_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 8'd0;
    accept     = 1'b0;
    cap_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          write_d  = req_write;
          size_d   = req_size;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          signed_d = req_signed_i;
          idx_d    = 2'd0;
          state_d  = ST_XFER;
        end
      end

      ST_XFER: begin
        mem_addr = xfer_addr;
        if (write_q) begin
          mem_write = 1'b1;
          mem_wdata = 8'(wdata_q >> {idx_q, 3'b000});
        end else begin
          mem_read = 1'b1;
          cap_en   = 1'b1;
        end
        if (last_byte) begin
          idx_d   = 2'd0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      ST_DONE: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State and latched-request registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      signed_q <= signed_d;
    end
  end

  // Load data lanes and extension; cleared on every accept so stores respond with zero
  mem_rd_assembler u_rd_asm (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .cap_en   (cap_en),
    .lane     (idx_q),
    .cap_byte (mem_rdata),
    .size     (size_q),
    .sext     (signed_q),
    .rdata    (resp_rdata)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a 16-byte memory model.
// Inputs driven and outputs sampled on the falling edge; cycle c = c-th cycle after accept.
// Optional sign-extension checks compile in when MEM_ACCESS_SIGN_EXT_EN is defined.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:15];
  logic       mem_load;

  logic        log_vld   [1:7];
  logic        log_rdy   [1:7];
  logic        log_wr    [1:7];
  logic        log_rd    [1:7];
  logic [31:0] log_addr  [1:7];
  logic [7:0]  log_wd    [1:7];
  logic [31:0] log_rdata [1:7];

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MEM_ACCESS_SIGN_EXT_EN
    .req_signed (req_signed),
`endif
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int k);
    case (k)
      0:       return 8'h81;
      1:       return 8'h02;
      2:       return 8'h03;
      3:       return 8'h04;
      15:      return 8'h10;
      default: return 8'(8'hA0 + k);
    endcase
  endfunction

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 16; k++) mem[k] <= init_byte(k);
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  // Issue one request at a falling edge (DUT idle) and log cycles 1..7 after the accept edge
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic sg);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL txn_ready_at_issue: req_ready=%b required 1", req_ready);
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_addr   = a;
    req_wdata  = wd;
    req_signed = sg;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      log_vld[c]   = resp_valid;
      log_rdy[c]   = req_ready;
      log_wr[c]    = mem_write;
      log_rd[c]    = mem_read;
      log_addr[c]  = mem_addr;
      log_wd[c]    = mem_wdata;
      log_rdata[c] = resp_rdata;
    end
  endtask

  task automatic test_reset;
    int first;
    int cnt;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_signed = 1'b0; mem_load = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, mem_write, mem_read} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy/vld/wr/rd=%b required 1000",
               {req_ready, resp_valid, mem_write, mem_read});
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 8'd0 || resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required all zero",
               mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk);
    mem_load = 1'b0;
    // release reset together with a word load; it must be taken on the very next edge
    reset = 1'b1;
    run_txn(1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (log_rd[1] !== 1'b1 || log_rdy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_accept: mem_read=%b req_ready=%b in cycle 1 required 1/0",
               log_rd[1], log_rdy[1]);
    end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (log_addr[c] !== 32'(c - 1) || log_rd[c] !== 1'b1 || log_wr[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL word_load_addr c%0d: addr=%h rd=%b wr=%b required %h/1/0",
                 c, log_addr[c], log_rd[c], log_wr[c], 32'(c - 1));
      end
    end
    first = 0; cnt = 0;
    for (int c = 1; c <= 7; c++) if (log_vld[c]) begin cnt++; if (first == 0) first = c; end
    n_checks++;
    if (first != 5 || cnt != 1) begin
      n_fail++;
      $display("FAIL word_load_latency: first=%0d count=%0d required 5/1", first, cnt);
    end
    n_checks++;
    if (log_rdata[5] !== 32'h04030281) begin
      n_fail++;
      $display("FAIL word_load_data: got %h required 04030281", log_rdata[5]);
    end
    n_checks++;
    if (log_addr[5] !== 32'd0 || log_rd[5] !== 1'b0 || log_rdy[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_idle_outputs: addr=%h rd=%b rdy6=%b required 0/0/1",
               log_addr[5], log_rd[5], log_rdy[6]);
    end
  endtask

  task automatic test_store_load;
    logic [7:0] exp_b [0:3];
    int first;
    int cnt;
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_txn(1'b1, 2'd2, 32'd4, 32'hDEADBEEF, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (log_wr[c] !== 1'b1 || log_rd[c] !== 1'b0 || log_addr[c] !== 32'(c + 3)
          || log_wd[c] !== exp_b[c-1]) begin
        n_fail++;
        $display("FAIL store_byte c%0d: wr=%b rd=%b addr=%h data=%h required 1/0/%h/%h",
                 c, log_wr[c], log_rd[c], log_addr[c], log_wd[c], 32'(c + 3), exp_b[c-1]);
      end
    end
    first = 0; cnt = 0;
    for (int c = 1; c <= 7; c++) if (log_vld[c]) begin cnt++; if (first == 0) first = c; end
    n_checks++;
    if (first != 5 || cnt != 1 || log_rdata[5] !== 32'd0) begin
      n_fail++;
      $display("FAIL store_resp: first=%0d count=%0d rdata=%h required 5/1/0",
               first, cnt, log_rdata[5]);
    end
    n_checks++;
    if (log_wr[5] !== 1'b0 || log_wd[5] !== 8'd0 || log_addr[5] !== 32'd0) begin
      n_fail++;
      $display("FAIL store_done_quiet: wr=%b wd=%h addr=%h required 0/0/0",
               log_wr[5], log_wd[5], log_addr[5]);
    end
    run_txn(1'b0, 2'd2, 32'd4, 32'd0, 1'b0);
    n_checks++;
    if (log_vld[5] !== 1'b1 || log_rdata[5] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_back: vld=%b rdata=%h required 1/deadbeef", log_vld[5], log_rdata[5]);
    end
    n_checks++;
    if (log_rdata[7] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h required deadbeef", log_rdata[7]);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a [1:4];
    run_txn(1'b0, 2'd1, 32'd15, 32'd0, 1'b0);
    n_checks++;
    if (log_addr[1] !== 32'd15 || log_addr[2] !== 32'd0) begin
      n_fail++;
      $display("FAIL half_wrap_addr: %h,%h required 0000000f,00000000", log_addr[1], log_addr[2]);
    end
    n_checks++;
    if (log_vld[3] !== 1'b1 || log_rdata[3] !== 32'h00008110) begin
      n_fail++;
      $display("FAIL half_wrap_data: vld=%b rdata=%h required 1/00008110", log_vld[3], log_rdata[3]);
    end
    exp_a[1] = 32'hABC0000E; exp_a[2] = 32'hABC0000F; exp_a[3] = 32'hABC00000; exp_a[4] = 32'hABC00001;
    run_txn(1'b0, 2'd3, 32'hABC0000E, 32'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (log_addr[c] !== exp_a[c]) begin
        n_fail++;
        $display("FAIL word_wrap_addr c%0d: got %h required %h", c, log_addr[c], exp_a[c]);
      end
    end
    n_checks++;
    if (log_rdata[5] !== 32'h028110AE) begin
      n_fail++;
      $display("FAIL word_wrap_data: got %h required 028110ae", log_rdata[5]);
    end
  endtask

  task automatic test_byte_load;
    run_txn(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
`ifdef MEM_ACCESS_SIGN_EXT_EN
    n_checks++;
    if (log_vld[2] !== 1'b1 || log_rdata[2] !== 32'hFFFFFF81) begin
      n_fail++;
      $display("FAIL byte_signed: vld=%b rdata=%h required 1/ffffff81", log_vld[2], log_rdata[2]);
    end
    run_txn(1'b0, 2'd1, 32'd15, 32'd0, 1'b1);
    n_checks++;
    if (log_rdata[3] !== 32'hFFFF8110) begin
      n_fail++;
      $display("FAIL half_signed: got %h required ffff8110", log_rdata[3]);
    end
    run_txn(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
`endif
    n_checks++;
    if (log_vld[2] !== 1'b1 || log_rdata[2] !== 32'h00000081) begin
      n_fail++;
      $display("FAIL byte_zero_ext: vld=%b rdata=%h required 1/00000081", log_vld[2], log_rdata[2]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [0:2];
    int acc [0:2];
    int n_acc;
    int n_busy;
    vals[0] = 32'h0000005A; vals[1] = 32'h000000C3; vals[2] = 32'h0000007E;
    n_acc = 0; n_busy = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
    for (int c = 0; c < 9; c++) begin
      if (req_ready && n_acc < 3) begin
        acc[n_acc] = c;
        req_addr   = 32'(12 + n_acc);
        req_wdata  = vals[n_acc];
        n_acc++;
      end else begin
        if (!req_ready) n_busy++;
        // garbage while busy: must not disturb the latched request
        req_addr  = 32'd0;
        req_wdata = 32'hFFFFFFFF;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (n_acc != 3 || n_busy != 6) begin
      n_fail++;
      $display("FAIL b2b_counts: accepts=%0d busy=%0d required 3/6", n_acc, n_busy);
    end
    n_checks++;
    if (n_acc == 3 && (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)) begin
      n_fail++;
      $display("FAIL b2b_spacing: accept cycles %0d,%0d,%0d required 3 apart", acc[0], acc[1], acc[2]);
    end
    n_checks++;
    if (mem[12] !== 8'h5A || mem[13] !== 8'hC3 || mem[14] !== 8'h7E || mem[0] !== 8'h81) begin
      n_fail++;
      $display("FAIL b2b_mem: mem12..14=%h,%h,%h mem0=%h required 5a,c3,7e,81",
               mem[12], mem[13], mem[14], mem[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer;
    logic saw_vld;
    saw_vld = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'd8; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'd9 || mem_wdata !== 8'h33) begin
      n_fail++;
      $display("FAIL mid_xfer_pre: wr=%b addr=%h wd=%h required 1/00000009/33",
               mem_write, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, mem_write, mem_read} !== 4'b1000 || mem_addr !== 32'd0
        || mem_wdata !== 8'd0 || resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_xfer_reset: rdy/vld/wr/rd=%b addr=%h wd=%h rdata=%h required 1000/0/0/0",
               {req_ready, resp_valid, mem_write, mem_read}, mem_addr, mem_wdata, resp_rdata);
    end
    repeat (3) begin @(negedge clk); if (resp_valid) saw_vld = 1'b1; end
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (resp_valid) saw_vld = 1'b1; end
    n_checks++;
    if (saw_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_resp: resp_valid seen=%b required 0", saw_vld);
    end
    n_checks++;
    if (mem[8] !== 8'h44 || mem[9] !== 8'hA9 || mem[10] !== 8'hAA || mem[11] !== 8'hAB) begin
      n_fail++;
      $display("FAIL abort_mem: mem8..11=%h,%h,%h,%h required 44,a9,aa,ab",
               mem[8], mem[9], mem[10], mem[11]);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_wrap;
    test_byte_load;
    test_back_to_back;
    test_reset_mid_xfer;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
